// File: rtl/seq_pkg.sv
// Shared types and default sizing for the framed sequence-scan controller.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAXLEN_DEF = 8;
  localparam int unsigned CNTW_DEF   = 8;
  localparam int unsigned FLW_DEF    = 16;

  function automatic int unsigned len_width(input int unsigned maxlen);
    return $clog2(maxlen + 1);
  endfunction

  localparam int unsigned LENW_DEF = len_width(MAXLEN_DEF);

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Serial bit stream handshake between the bit source and the scan controller.
interface seq_scan_ctrl_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/seq_match_window.sv
// History shift register, fill counter and masked pattern compare for one job.
module seq_match_window
  import seq_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en,
  input  logic                         shift_bit,
  input  logic                         clear,
  input  logic [$clog2(MAXLEN+1)-1:0]  len,
  input  logic                         overlap,
  input  logic [MAXLEN-1:0]            pattern,
  output logic                         match_c
);

  localparam int unsigned LENW = $clog2(MAXLEN + 1);
  localparam int unsigned MW   = MAXLEN + 1;
  localparam int unsigned FW   = LENW + 1;

  logic [MAXLEN-1:0] hist;
  logic [MAXLEN-1:0] hist_nx;
  logic [MAXLEN-1:0] mask;
  logic [MW-1:0]     mask_w;
  logic [LENW-1:0]   fill;
  logic [FW-1:0]     fill_inc;

  // Compare the would-be history against the pattern, restricted to len bits.
  always_comb begin
    hist_nx  = {hist[MAXLEN-2:0], shift_bit};
    fill_inc = {1'b0, fill} + FW'(1);
    mask_w   = (MW'(1) << len) - MW'(1);
    mask     = mask_w[MAXLEN-1:0];
    match_c  = shift_en && (fill_inc >= {1'b0, len}) &&
               (((hist_nx ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nx;
      if (match_c && !overlap) begin
        fill <= '0;
      end else if (fill_inc >= {1'b0, len}) begin
        fill <= len;
      end else begin
        fill <= fill_inc[LENW-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Framed sequence-detection controller: config, job FSM, bit counting and match tally.
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEF,
  parameter int unsigned CNTW   = CNTW_DEF,
  parameter int unsigned FLW    = FLW_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [MAXLEN-1:0]            cfg_pattern,
  input  logic [$clog2(MAXLEN+1)-1:0]  cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         start,
  input  logic [FLW-1:0]               frame_len,
  input  logic                         abort,
  seq_scan_ctrl_if.slave               bus,
  output logic                         busy,
  output logic                         match,
  output logic [CNTW-1:0]              match_count,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned LENW = $clog2(MAXLEN + 1);

  state_t            state;
  logic [MAXLEN-1:0] pattern_q;
  logic [LENW-1:0]   len_q;
  logic              overlap_q;
  logic [FLW-1:0]    frame_len_q;
  logic [FLW-1:0]    bit_cnt;
  logic              in_ready_q;
  logic              cfg_ok_c;
  logic              start_ok_c;
  logic              accept_c;
  logic              win_match_c;

  assign bus.in_ready = in_ready_q;

  // Start qualification uses the stored config, so a same-cycle write cannot affect it.
  always_comb begin
    cfg_ok_c   = (len_q != '0) && (len_q <= LENW'(MAXLEN)) && (frame_len != '0);
    start_ok_c = (state == IDLE) && start && cfg_ok_c;
    accept_c   = (state == RUN) && bus.in_valid && in_ready_q && !abort;
  end

  seq_match_window #(.MAXLEN(MAXLEN)) u_window (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (accept_c),
    .shift_bit (bus.in_bit),
    .clear     (start_ok_c),
    .len       (len_q),
    .overlap   (overlap_q),
    .pattern   (pattern_q),
    .match_c   (win_match_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      frame_len_q <= '0;
      bit_cnt     <= '0;
      in_ready_q  <= 1'b0;
      busy        <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
          end
          if (start) begin
            if (start_ok_c) begin
              state       <= RUN;
              in_ready_q  <= 1'b1;
              busy        <= 1'b1;
              match_count <= '0;
              bit_cnt     <= '0;
              frame_len_q <= frame_len;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
          end else if (accept_c) begin
            bit_cnt <= bit_cnt + FLW'(1);
            match   <= win_match_c;
            if (win_match_c && (match_count != '1)) begin
              match_count <= match_count + CNTW'(1);
            end
            if ((bit_cnt + FLW'(1)) == frame_len_q) begin
              state      <= DONE;
              in_ready_q <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl against a stream-level match model.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       start;
  logic [15:0] frame_len;
  logic       abort;
  logic       busy, match, done, err;
  logic [7:0] match_count;

  seq_scan_ctrl_if bus ();

  seq_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .start       (start),
    .frame_len   (frame_len),
    .abort       (abort),
    .bus         (bus.slave),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;
  bit stream[$];
  bit exp_q[$];

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Expected match per accepted bit: last len bits of the current segment equal the pattern.
  task automatic build_exp(input logic [7:0] pat, input int len, input bit ov, input int nbits);
    int seg = 0;
    bit hit;
    exp_q.delete();
    for (int i = 0; i < nbits; i++) begin
      hit = (i - seg + 1 >= len);
      for (int k = 0; k < len; k++) begin
        if (hit && (stream[i-k] != pat[k])) hit = 1'b0;
      end
      exp_q.push_back(hit);
      if (hit && !ov) seg = i + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] pat, input int len, input bit ov);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = 4'(len); cfg_overlap = ov;
    tick();
    cfg_we = 1'b0;
  endtask

  // Configure, start and stream one frame; gap 0=none 1=toggle 2=random; abort_at<0 = no abort.
  task automatic run_job(input logic [7:0] pat, input int len, input bit ov, input int flen,
                         input int gap, input int abort_at, input bit cfg_noise, output int total);
    int  idx = 0;
    int  cyc = 0;
    int  budget;
    bit  last_acc = 1'b0;
    bit  abort_now;
    bit  rdy;
    bit  exp_m, exp_d;
    total = 0;
    budget = flen * 8 + 50;
    build_exp(pat, len, ov, flen);
    write_cfg(pat, len, ov);
    start = 1'b1; frame_len = 16'(flen);
    tick();
    start = 1'b0;
    nchecks++;
    if (err !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1 || match_count !== 8'd0) begin
      nerr++;
      $display("FAIL job_start: err=%b busy=%b in_ready=%b count=%0d, required 0 1 1 0",
               err, busy, bus.in_ready, match_count);
    end
    forever begin
      if (cyc > budget) begin
        nerr++; nchecks++;
        $display("FAIL job_timeout: accepted %0d bits, required %0d", idx, flen);
        break;
      end
      exp_m = last_acc ? exp_q[idx-1] : 1'b0;
      exp_d = last_acc && (idx == flen);
      if (exp_m) total++;
      nchecks++;
      if (match !== exp_m || done !== exp_d || match_count !== 8'(sat(total))) begin
        nerr++;
        $display("FAIL job_bit%0d: match=%b done=%b count=%0d, required %b %b %0d",
                 idx, match, done, match_count, exp_m, exp_d, sat(total));
      end
      if (exp_d) begin
        nchecks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
          nerr++;
          $display("FAIL done_cycle: in_ready=%b busy=%b, required 0 1", bus.in_ready, busy);
        end
        tick();
        nchecks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || match !== 1'b0 ||
            match_count !== 8'(sat(total))) begin
          nerr++;
          $display("FAIL after_done: in_ready=%b busy=%b done=%b match=%b count=%0d, required 0 0 0 0 %0d",
                   bus.in_ready, busy, done, match, match_count, sat(total));
        end
        break;
      end
      case (gap)
        0: bus.in_valid = 1'b1;
        1: bus.in_valid = (cyc % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_bit = stream[idx];
      abort_now = (abort_at == idx);
      abort = abort_now;
      if (abort_now) bus.in_valid = 1'b1;
      if (cfg_noise) begin
        cfg_we = 1'($urandom_range(0, 1));
        cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_overlap = 1'($urandom);
      end
      rdy = bus.in_ready;
      nchecks++;
      if (rdy !== 1'b1) begin
        nerr++;
        $display("FAIL run_ready: in_ready=%b, required 1", rdy);
      end
      tick();
      cyc++;
      last_acc = bus.in_valid && rdy && !abort_now;
      if (last_acc) idx++;
      abort = 1'b0;
      cfg_we = 1'b0;
      if (abort_now) begin
        bus.in_valid = 1'b0;
        nchecks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0 || match !== 1'b0 || done !== 1'b0 ||
            match_count !== 8'(sat(total))) begin
          nerr++;
          $display("FAIL abort: busy=%b in_ready=%b match=%b done=%b count=%0d, required 0 0 0 0 %0d",
                   busy, bus.in_ready, match, done, match_count, sat(total));
        end
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic load_stream(input logic [15:0] v, input int n);
    stream.delete();
    for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic expect_err(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    nchecks++;
    if (err !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL %s: err=%b busy=%b in_ready=%b, required 1 0 0", name, err, busy, bus.in_ready);
    end
    tick();
    nchecks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_pulse: err=%b busy=%b, required 0 0", name, err, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    nchecks++;
    if (busy !== 0 || match !== 0 || done !== 0 || err !== 0 || bus.in_ready !== 0 ||
        match_count !== 8'd0) begin
      nerr++;
      $display("FAIL reset: busy=%b match=%b done=%b err=%b in_ready=%b count=%0d, required all 0",
               busy, match, done, err, bus.in_ready, match_count);
    end
    rst = 1'b0;
    frame_len = 16'd5;
    expect_err("reset_cfg_zero");
  endtask

  task automatic test_overlap();
    int t;
    load_stream(16'b1011011, 7);
    run_job(8'b1011, 4, 1'b1, 7, 0, -1, 1'b0, t);
    nchecks++;
    if (t != 2) begin nerr++; $display("FAIL overlap_total: model=%0d, required 2", t); end
  endtask

  task automatic test_nonoverlap();
    int t;
    load_stream(16'b1011011, 7);
    run_job(8'b1011, 4, 1'b0, 7, 0, -1, 1'b0, t);
    nchecks++;
    if (t != 1) begin nerr++; $display("FAIL nonoverlap_total: model=%0d, required 1", t); end
  endtask

  task automatic test_saturate();
    int t;
    stream.delete();
    for (int i = 0; i < 300; i++) stream.push_back(1'b1);
    run_job(8'b1, 1, 1'b1, 300, 1, -1, 1'b0, t);
    nchecks++;
    if (match_count !== 8'd255) begin
      nerr++; $display("FAIL saturate: count=%0d, required 255", match_count);
    end
  endtask

  task automatic test_err();
    write_cfg(8'b101, 0, 1'b0);
    frame_len = 16'd4;
    expect_err("err_len0");
    write_cfg(8'b101, 9, 1'b0);
    expect_err("err_len_big");
    write_cfg(8'b101, 3, 1'b0);
    frame_len = 16'd0;
    expect_err("err_frame0");
  endtask

  task automatic test_cfg_same_cycle();
    write_cfg(8'b11, 2, 1'b1);
    cfg_we = 1'b1; cfg_len = 4'd0; start = 1'b1; frame_len = 16'd5;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    nchecks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL cfg_same_cycle: err=%b busy=%b, required 0 1", err, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    frame_len = 16'd5;
    expect_err("cfg_loaded_idle");
  endtask

  task automatic test_abort();
    int t;
    stream.delete();
    for (int i = 0; i < 8; i++) stream.push_back(1'b1);
    run_job(8'b1, 1, 1'b1, 8, 0, 3, 1'b0, t);
    nchecks++;
    if (match_count !== 8'd3) begin
      nerr++; $display("FAIL abort_partial: count=%0d, required 3", match_count);
    end
    load_stream(16'b0110, 4);
    run_job(8'b10, 2, 1'b1, 4, 0, -1, 1'b0, t);
  endtask

  task automatic test_rst_mid();
    int t;
    write_cfg(8'b1, 1, 1'b1);
    start = 1'b1; frame_len = 16'd8;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    tick(); tick(); tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nchecks++;
    if (busy !== 0 || match !== 0 || done !== 0 || err !== 0 || bus.in_ready !== 0 ||
        match_count !== 8'd0) begin
      nerr++;
      $display("FAIL rst_mid: busy=%b match=%b done=%b err=%b in_ready=%b count=%0d, required all 0",
               busy, match, done, err, bus.in_ready, match_count);
    end
    frame_len = 16'd4;
    expect_err("rst_cfg_cleared");
    load_stream(16'b1101, 4);
    run_job(8'b101, 3, 1'b1, 4, 0, -1, 1'b0, t);
  endtask

  task automatic test_random();
    int t, len, flen;
    logic [7:0] pat;
    for (int j = 0; j < 8; j++) begin
      len  = $urandom_range(1, 8);
      flen = $urandom_range(1, 40);
      pat  = 8'($urandom);
      stream.delete();
      for (int i = 0; i < flen; i++) stream.push_back(1'($urandom_range(0, 1)));
      run_job(pat, len, 1'($urandom_range(0, 1)), flen, 2, -1, 1'b1, t);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; frame_len = '0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_saturate();
    test_err();
    test_cfg_same_cycle();
    test_abort();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Programmable controller that runs framed sequence-detection jobs over a serial bitstream. It holds a software-written pattern (1..MAXLEN bits, overlapping or non-overlapping mode) and accepts a fixed-length frame of bits under a valid/ready handshake. It reports each match as a pulse and the saturating match total at frame end. It sits between the bit source and the status/interrupt logic and replaces per-pattern hard-coded detector FSMs.

## Interface
- MAXLEN, 8, maximum pattern length in bits (2..16)
- CNTW, 8, match counter width
- FLW, 16, frame length width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  config write strobe; honoured only in IDLE
- cfg_pattern  in  MAXLEN  pattern; bit [len-1] is the first bit received
- cfg_len  in  clog2(MAXLEN+1)  pattern length
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- start  in  1  begin job; frame_len sampled here
- frame_len  in  FLW  bits per frame
- abort  in  1  cancel running job
- in_valid  in  1  source has a bit
- in_bit  in  1  data bit
- in_ready  out  1  controller accepts a bit
- busy  out  1  job active (RUN or DONE)
- match  out  1  one-cycle pulse per detection
- match_count  out  CNTW  matches in current/last frame, saturating
- done  out  1  one-cycle pulse at frame end
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE. All outputs 0. Config regs 0. History, fill, bit counter 0.
- IDLE: cfg_we loads pattern, len and overlap. Writing during RUN or DONE has no effect.
- start in IDLE:
  - Rejected when stored len==0, len>MAXLEN or frame_len==0. Response: err=1 next cycle; state stays IDLE.
  - Otherwise: go to RUN. Clear match_count, history, fill and bit_cnt. Latch frame_len.
- start outside IDLE is ignored. When cfg_we and start occur in the same cycle, start uses the old config.
- RUN: in_ready=1. A bit is accepted on each cycle with in_valid && in_ready. On accept:
  - hist <= {hist[MAXLEN-2:0], in_bit}.
  - fill <= min(fill+1, len).
  - bit_cnt++.
- Match condition: (fill+1 >= len) and the low len bits of the new hist equal the low len bits of pattern.
  - Overlap mode: fill is unaffected by a match.
  - Non-overlap mode: fill is cleared to 0 on a match.
- match_count increments on every match and saturates at all-ones.
- The accept that makes bit_cnt equal frame_len moves the FSM to DONE.
- DONE: lasts exactly 1 cycle. done=1, in_ready=0. Then the FSM returns to IDLE. match_count holds until the next accepted start.
- abort in RUN: go to IDLE next cycle. No done. A bit accepted in the same cycle as abort is discarded, so no match results from it. match_count keeps its partial value.
- rst in any state overrides everything, including mid-frame.

## Timing
- match is registered. It is high in the cycle after the accept of the completing bit. match_count updates on the same edge.
- The final bit's match and done appear together in the DONE cycle.
- in_ready falls in the DONE cycle. It stays 0 in IDLE.
- Throughput is 1 bit/cycle. Gaps in in_valid stall the job without any loss of state.
- Latency from start to in_ready=1 is 1 cycle.

## Structure
- Package seq_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default MAXLEN, CNTW and FLW;
  - the clog2-based length width constant.
- Sub-module seq_match_window contains:
  - the history shift register;
  - the fill counter;
  - the masked pattern compare (len-bit mask).
- Its ports are shift-enable, clear, len, overlap, pattern and the match output. The top level holds the FSM, bit_cnt, match_count and the handshake.

## Test plan
- Pattern 1011, len 4, overlap=1, frame_len 7, stream 1011011 (no gaps) → match pulses after bit 4 and bit 7. done is with the 2nd match. match_count=2.
- Same pattern, overlap=0, same stream → one match after bit 4. match_count=1.
- Pattern 1, len 1, CNTW=8, frame_len 300, all ones, in_valid toggling 1/0 → 300 match pulses. match_count=255. done 1 cycle after bit 300 accept.
- start with len=0, or frame_len=0 → err pulse. busy stays 0. in_ready stays 0.
- abort after 3 of 8 bits → IDLE next cycle. No done. cfg_we is then accepted. A new start clears match_count.
- rst asserted mid-frame → all outputs 0 the next cycle. A subsequent start with frame_len 4 runs cleanly.
